// File: rtl/mdr_mem_interface_pkg.sv
// Shared types and defaults for the MDR memory-side stage: FSM state encoding,
// default widths and the registered status bundle.
package mdr_mem_interface_pkg;

   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_ADDR_WIDTH     = 9;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 15;
   localparam int unsigned CNT_WIDTH          = 8;

   // Encodings are shared with the control unit and must not be reordered
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   typedef struct packed {
      logic rd_req;
      logic wr_req;
      logic busy;
      logic done;
      logic timeout_err;
   } status_t;

endpackage

// File: rtl/mdr_mem_interface_if.sv
// Control-unit / RAM facing signal bundle of the MDR memory stage.
// The slave modport is the stage itself; master is the surrounding system.
interface mdr_mem_interface_if
   import mdr_mem_interface_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic [DATA_WIDTH-1:0] bus_mux_out;
   logic                  mar_in;
   logic                  mdr_in;
   logic                  mdr_read;
   logic                  mdr_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_req;
   logic                  mem_wr_req;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mdr_out_data;
   logic                  busy;
   logic                  done;
   logic                  timeout_err;

   modport master (
      output bus_mux_out, mar_in, mdr_in, mdr_read, mdr_write, mem_rdata, mem_ack,
      input  mem_addr, mem_rd_req, mem_wr_req, mem_wdata, mdr_out_data,
             busy, done, timeout_err
   );

   modport slave (
      input  bus_mux_out, mar_in, mdr_in, mdr_read, mdr_write, mem_rdata, mem_ack,
      output mem_addr, mem_rd_req, mem_wr_req, mem_wdata, mdr_out_data,
             busy, done, timeout_err
   );

endinterface

// File: rtl/mdr_mem_interface_wait_counter.sv
// Memory wait counter: synchronous clear, count enable, saturation at all-ones,
// and a terminal-count compare used for the ack timeout.
module mdr_mem_interface_wait_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned TERMINAL = 14
) (
   input  logic clk,
   input  logic clr,
   input  logic clear,
   input  logic enable,
   output logic last_c
);

   logic [WIDTH-1:0] count;

   // Clear wins over enable; holds at all-ones instead of wrapping
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

   assign last_c = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/mdr_mem_interface.sv
// MDR memory-side stage: MAR/MDR registers and a single-word read/write
// transaction FSM with req/ack handshake and ack timeout.
module mdr_mem_interface
   import mdr_mem_interface_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic                clk,
   input logic                clr,
   mdr_mem_interface_if.slave bus
);

   state_e                state, state_nxt;
   logic [ADDR_WIDTH-1:0] mar, mar_nxt;
   logic [DATA_WIDTH-1:0] mdr, mdr_nxt;
   status_t               status_q, status_d;
   logic                  cnt_clear;
   logic                  cnt_en;
   logic                  cnt_last_c;

   mdr_mem_interface_wait_counter #(
      .WIDTH    (CNT_WIDTH),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_wait_counter (
      .clk    (clk),
      .clr    (clr),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .last_c (cnt_last_c)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= ST_IDLE;
         mar      <= '0;
         mdr      <= '0;
         status_q <= '0;
      end else begin
         state    <= state_nxt;
         mar      <= mar_nxt;
         mdr      <= mdr_nxt;
         status_q <= status_d;
      end
   end

   // Next state, register loads and status decode from the next state
   always_comb begin
      state_nxt = state;
      mar_nxt   = mar;
      mdr_nxt   = mdr;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      status_d  = '0;
      status_d.timeout_err = status_q.timeout_err;

      case (state)
         ST_IDLE: begin
            if (bus.mar_in) mar_nxt = bus.bus_mux_out[ADDR_WIDTH-1:0];
            if (bus.mdr_in) mdr_nxt = bus.bus_mux_out;
            if (bus.mdr_read || bus.mdr_write) begin
               cnt_clear            = 1'b1;
               status_d.timeout_err = 1'b0;
               state_nxt            = bus.mdr_read ? ST_RD_WAIT : ST_WR_WAIT;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            cnt_en = ~bus.mem_ack;
            // An ack on the terminal cycle still counts as success
            if (bus.mem_ack) begin
               if (state == ST_RD_WAIT) mdr_nxt = bus.mem_rdata;
               state_nxt = ST_DONE;
            end else if (cnt_last_c) begin
               status_d.timeout_err = 1'b1;
               state_nxt            = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      status_d.rd_req = (state_nxt == ST_RD_WAIT);
      status_d.wr_req = (state_nxt == ST_WR_WAIT);
      status_d.busy   = (state_nxt != ST_IDLE);
      status_d.done   = (state_nxt == ST_DONE);
   end

   assign bus.mem_addr     = mar;
   assign bus.mem_wdata    = mdr;
   assign bus.mdr_out_data = mdr;
   assign bus.mem_rd_req   = status_q.rd_req;
   assign bus.mem_wr_req   = status_q.wr_req;
   assign bus.busy         = status_q.busy;
   assign bus.done         = status_q.done;
   assign bus.timeout_err  = status_q.timeout_err;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Directed bench for mdr_mem_interface with a scoreboard of expected MDR/MAR
// values per transaction, popped when the stage signals done.
module tb_mdr_mem_interface;
   import mdr_mem_interface_pkg::*;

   logic clk = 1'b0;
   logic clr;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [8:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   mdr_mem_interface_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus ();

   mdr_mem_interface #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (9),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_idle(input string tag, input logic [8:0] addr,
                                     input logic [31:0] mdr, input logic err);
      check({tag, "_rd_req"}, 32'(bus.mem_rd_req), 32'd0);
      check({tag, "_wr_req"}, 32'(bus.mem_wr_req), 32'd0);
      check({tag, "_busy"},   32'(bus.busy),       32'd0);
      check({tag, "_done"},   32'(bus.done),       32'd0);
      check({tag, "_err"},    32'(bus.timeout_err), 32'(err));
      check({tag, "_addr"},   32'(bus.mem_addr),   32'(addr));
      check({tag, "_wdata"},  bus.mem_wdata,       mdr);
      check({tag, "_mdr"},    bus.mdr_out_data,    mdr);
   endtask

   // Starts at the sample just after the accepting edge; drives mem_ack in
   // the ack_on-th request cycle (0 = never) and stops at done or at idle.
   task automatic run_txn(input int ack_on, input logic [31:0] rdata,
                          output int req_cycles, output int edges, output bit saw_done);
      bit finished = 1'b0;
      req_cycles = 0;
      edges      = 0;
      saw_done   = 1'b0;
      bus.mem_rdata = rdata;
      for (int i = 0; i < 64; i++) begin
         if (bus.done) begin
            saw_done = 1'b1;
            finished = 1'b1;
            break;
         end
         if (!bus.busy) begin
            finished = 1'b1;
            break;
         end
         if (bus.mem_rd_req || bus.mem_wr_req) req_cycles++;
         bus.mem_ack = (req_cycles == ack_on);
         tick();
         edges++;
      end
      bus.mem_ack = 1'b0;
      check("txn_finished", 32'(finished), 32'd1);
   endtask

   task automatic sb_pop_check();
      exp_t e;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({e.tag, "_done_mdr"},  bus.mdr_out_data,    e.data);
         check({e.tag, "_done_addr"}, 32'(bus.mem_addr),   32'(e.addr));
         check({e.tag, "_done_req"},  32'(bus.mem_rd_req | bus.mem_wr_req), 32'd0);
         check({e.tag, "_done_busy"}, 32'(bus.busy),       32'd1);
      end
   endtask

   int  rc, ed;
   bit  dn;

   initial begin
      clr             = 1'b1;
      bus.bus_mux_out = '0;
      bus.mar_in      = 1'b0;
      bus.mdr_in      = 1'b0;
      bus.mdr_read    = 1'b0;
      bus.mdr_write   = 1'b0;
      bus.mem_rdata   = '0;
      bus.mem_ack     = 1'b0;
      tick();
      tick();
      check_outputs_idle("reset", 9'h000, 32'h0, 1'b0);
      clr = 1'b0;
      tick();

      // 1: reset while a read request is outstanding
      bus.bus_mux_out = 32'h0000_0155; bus.mar_in = 1'b1; bus.mdr_in = 1'b1;
      tick();
      bus.mar_in = 1'b0; bus.mdr_in = 1'b0;
      check("t1_mar", 32'(bus.mem_addr), 32'h155);
      check("t1_mdr", bus.mdr_out_data, 32'h0000_0155);
      bus.mdr_read = 1'b1;
      tick();
      bus.mdr_read = 1'b0;
      check("t1_rd_req", 32'(bus.mem_rd_req), 32'd1);
      clr = 1'b1;
      #1;
      check_outputs_idle("t1_clr", 9'h000, 32'h0, 1'b0);
      tick();
      clr = 1'b0;
      tick();

      // 2: write with ack on the third request cycle
      bus.bus_mux_out = 32'h0000_00A5; bus.mar_in = 1'b1;
      tick();
      bus.mar_in = 1'b0;
      bus.bus_mux_out = 32'hDEAD_BEEF; bus.mdr_in = 1'b1;
      tick();
      bus.mdr_in = 1'b0;
      bus.mdr_write = 1'b1;
      sb.push_back('{"t2", 9'h0A5, 32'hDEAD_BEEF});
      tick();
      bus.mdr_write = 1'b0;
      check("t2_wr_req",   32'(bus.mem_wr_req), 32'd1);
      check("t2_rd_req",   32'(bus.mem_rd_req), 32'd0);
      check("t2_mem_addr", 32'(bus.mem_addr), 32'h0A5);
      check("t2_wdata",    bus.mem_wdata, 32'hDEAD_BEEF);
      run_txn(3, 32'h0, rc, ed, dn);
      check("t2_req_cycles", 32'(rc), 32'd3);
      check("t2_done_seen",  32'(dn), 32'd1);
      if (dn) sb_pop_check();
      tick();
      check("t2_done_width", 32'(bus.done), 32'd0);
      check("t2_idle",       32'(bus.busy), 32'd0);

      // 3: zero-wait read, done one edge after acceptance
      bus.mdr_read = 1'b1;
      sb.push_back('{"t3", 9'h0A5, 32'h1234_5678});
      tick();
      bus.mdr_read = 1'b0;
      run_txn(1, 32'h1234_5678, rc, ed, dn);
      check("t3_req_cycles", 32'(rc), 32'd1);
      check("t3_edges",      32'(ed), 32'd1);
      check("t3_done_seen",  32'(dn), 32'd1);
      if (dn) sb_pop_check();
      // New command presented in the done cycle is ignored
      bus.mdr_write = 1'b1;
      tick();
      bus.mdr_write = 1'b0;
      check("t3_cmd_in_done", 32'(bus.busy), 32'd0);

      // 4: read has priority; bus loads ignored while busy
      bus.mdr_read = 1'b1; bus.mdr_write = 1'b1;
      sb.push_back('{"t4", 9'h0A5, 32'hCAFE_0004});
      tick();
      bus.mdr_read = 1'b0; bus.mdr_write = 1'b0;
      check("t4_rd_req", 32'(bus.mem_rd_req), 32'd1);
      check("t4_wr_req", 32'(bus.mem_wr_req), 32'd0);
      bus.bus_mux_out = 32'h0000_01FF; bus.mar_in = 1'b1; bus.mdr_in = 1'b1;
      tick();
      bus.mar_in = 1'b0; bus.mdr_in = 1'b0;
      check("t4_mar_held", 32'(bus.mem_addr), 32'h0A5);
      check("t4_mdr_held", bus.mdr_out_data, 32'h1234_5678);
      run_txn(1, 32'hCAFE_0004, rc, ed, dn);
      check("t4_done_seen", 32'(dn), 32'd1);
      if (dn) sb_pop_check();
      tick();

      // 5: no ack -> timeout after 15 request cycles, then cleared by next read
      bus.mdr_read = 1'b1;
      tick();
      bus.mdr_read = 1'b0;
      run_txn(0, 32'hBAD0_BAD0, rc, ed, dn);
      check("t5_req_cycles", 32'(rc), 32'd15);
      check("t5_no_done",    32'(dn), 32'd0);
      check_outputs_idle("t5_after", 9'h0A5, 32'hCAFE_0004, 1'b1);
      tick();
      check("t5_err_sticky", 32'(bus.timeout_err), 32'd1);
      bus.mdr_read = 1'b1;
      sb.push_back('{"t5b", 9'h0A5, 32'h0505_0505});
      tick();
      bus.mdr_read = 1'b0;
      check("t5_err_cleared", 32'(bus.timeout_err), 32'd0);
      run_txn(2, 32'h0505_0505, rc, ed, dn);
      check("t5b_done_seen", 32'(dn), 32'd1);
      if (dn) sb_pop_check();
      tick();

      // 6: ack on the 15th wait cycle is still a success
      bus.bus_mux_out = 32'h0000_0033; bus.mar_in = 1'b1;
      bus.mdr_read = 1'b1;
      sb.push_back('{"t6", 9'h033, 32'h6666_0015});
      tick();
      bus.mar_in = 1'b0; bus.mdr_read = 1'b0;
      check("t6_new_mar", 32'(bus.mem_addr), 32'h033);
      run_txn(15, 32'h6666_0015, rc, ed, dn);
      check("t6_req_cycles", 32'(rc), 32'd15);
      check("t6_done_seen",  32'(dn), 32'd1);
      check("t6_err",        32'(bus.timeout_err), 32'd0);
      if (dn) sb_pop_check();
      tick();
      check("t6_idle_err", 32'(bus.timeout_err), 32'd0);

      // Stray ack while idle must not disturb anything
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      bus.mem_ack = 1'b0;
      check_outputs_idle("idle_ack", 9'h033, 32'h6666_0015, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
